// File: rtl/nw_multiplexer.sv
// N-way registered multiplexer with valid/ready on every input channel and on the output.
// A channel is chosen by external select (mode 0) or by round-robin arbitration (mode 1).
module nw_multiplexer #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_i,
  input  logic [SELW-1:0]    sel_i,
  input  logic [N-1:0]       in_valid_i,
  input  logic [N*WIDTH-1:0] in_data_i,
  output logic [N-1:0]       in_ready_o,
  output logic               out_valid_o,
  output logic [WIDTH-1:0]   out_data_o,
  output logic [SELW-1:0]    out_chan_o,
  input  logic               out_ready_i
);

  logic             load_en;
  logic             grant_valid;
  logic             xfer;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_chan_q,  out_chan_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  assign load_en = !out_valid_q || out_ready_i;
  assign xfer    = load_en && grant_valid;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (!mode_i) begin
      for (int i = 0; i < N; i++) begin
        if (sel_i == SELW'(i) && in_valid_i[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SELW'(i);
        end
      end
    end else begin
      // Last write wins: the wrap-around pass (below ptr) is overridden by the pass at or above ptr,
      // and the descending order makes the lowest index win within each pass.
      for (int i = N - 1; i >= 0; i--) begin
        if (SELW'(i) < ptr_q && in_valid_i[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SELW'(i);
        end
      end
      for (int i = N - 1; i >= 0; i--) begin
        if (SELW'(i) >= ptr_q && in_valid_i[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data = in_data_i[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    in_ready_o = '0;
    if (xfer && !rst) begin
      in_ready_o[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_chan_d  = grant_idx;
      ptr_d       = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_chan_o  = out_chan_q;

endmodule

// File: tb/tb_nw_multiplexer.sv
// Scoreboard bench for nw_multiplexer: an N=4 and an N=3 instance share inputs and are
// each checked every cycle against a reference model of grant, ready and output stream.
module tb_nw_multiplexer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  inValid;
  logic [31:0] inData;
  logic        outReady;

  logic [3:0]  ready4;
  logic [2:0]  ready3;
  logic        ov4, ov3;
  logic [7:0]  od4, od3;
  logic [1:0]  oc4, oc3;

  int          checks = 0;
  int          errors = 0;
  int          mPtr[2];
  logic        mValid[2];
  logic [15:0] sb4[$];
  logic [15:0] sb3[$];
  int          chanCount[4];

  always #5 clk = ~clk;

  nw_multiplexer #(.WIDTH(8), .N(4)) dut4 (
    .clk(clk), .rst(rst), .mode_i(mode), .sel_i(sel),
    .in_valid_i(inValid), .in_data_i(inData), .in_ready_o(ready4),
    .out_valid_o(ov4), .out_data_o(od4), .out_chan_o(oc4), .out_ready_i(outReady)
  );

  nw_multiplexer #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .rst(rst), .mode_i(mode), .sel_i(sel),
    .in_valid_i(inValid[2:0]), .in_data_i(inData[23:0]), .in_ready_o(ready3),
    .out_valid_o(ov3), .out_data_o(od3), .out_chan_o(oc3), .out_ready_i(outReady)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int modelGrant(input int n, input logic md, input logic [1:0] s,
                                    input logic [3:0] v, input int p);
    int idx;
    if (!md) begin
      if (int'(s) < n && v[s]) return int'(s);
      return -1;
    end
    for (int k = 0; k < n; k++) begin
      idx = (p + k) % n;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic md, input logic [1:0] s, input logic [3:0] v, input logic rdy);
    mode     = md;
    sel      = s;
    inValid  = v;
    outReady = rdy;
  endtask

  task automatic setData(input logic [7:0] base);
    for (int i = 0; i < 4; i++) inData[i*8 +: 8] = base + 8'(i);
  endtask

  task automatic resetModels();
    mPtr[0] = 0; mPtr[1] = 0;
    mValid[0] = 1'b0; mValid[1] = 1'b0;
    sb4.delete();
    sb3.delete();
  endtask

  task automatic checkResetState();
    checkOutput("rst_valid4", 32'(ov4), 0);
    checkOutput("rst_data4", 32'(od4), 0);
    checkOutput("rst_chan4", 32'(oc4), 0);
    checkOutput("rst_ready4", 32'(ready4), 0);
    checkOutput("rst_valid3", 32'(ov3), 0);
    checkOutput("rst_ready3", 32'(ready3), 0);
  endtask

  // One clock: check the pre-edge state of both instances, then advance the models.
  task automatic runCycle();
    int          nextPtr[2];
    logic        nextValid[2];
    int          n, g;
    logic        loadEn, obsValid;
    logic [3:0]  obsReady, expReady;
    logic [15:0] obsWord, front, word;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n            = (d == 0) ? 4 : 3;
      nextPtr[d]   = mPtr[d];
      nextValid[d] = mValid[d];
      obsReady     = (d == 0) ? ready4 : {1'b0, ready3};
      obsValid     = (d == 0) ? ov4 : ov3;
      obsWord      = (d == 0) ? {6'b0, oc4, od4} : {6'b0, oc3, od3};
      loadEn       = !mValid[d] || outReady;
      g            = modelGrant(n, mode, sel, inValid, mPtr[d]);
      expReady     = (loadEn && g >= 0) ? 4'(1 << g) : 4'b0;
      checkOutput($sformatf("in_ready_n%0d", n), 32'(obsReady), 32'(expReady));
      checkOutput($sformatf("out_valid_n%0d", n), 32'(obsValid), 32'(mValid[d]));
      if (mValid[d] && ((d == 0) ? sb4.size() : sb3.size()) > 0) begin
        front = (d == 0) ? sb4[0] : sb3[0];
        checkOutput($sformatf("out_data_n%0d", n), 32'(obsWord[7:0]), 32'(front[7:0]));
        checkOutput($sformatf("out_chan_n%0d", n), 32'(obsWord[15:8]), 32'(front[15:8]));
        if (outReady) begin
          if (d == 0) begin
            void'(sb4.pop_front());
            chanCount[int'(front[15:8])]++;
          end else begin
            void'(sb3.pop_front());
          end
        end
      end
      if (loadEn && g >= 0) begin
        word = {8'(g), inData[g*8 +: 8]};
        if (d == 0) sb4.push_back(word);
        else        sb3.push_back(word);
        nextPtr[d]   = (g == n - 1) ? 0 : g + 1;
        nextValid[d] = 1'b1;
      end else if (loadEn) begin
        nextValid[d] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      mPtr[d]   = nextPtr[d];
      mValid[d] = nextValid[d];
    end
  endtask

  initial begin
    applyStimulus(1'b0, 2'd0, 4'b0000, 1'b0);
    inData = '0;
    rst    = 1'b1;
    #12;
    checkResetState();
    @(posedge clk);
    #1;
    rst = 1'b0;
    resetModels();

    // Fixed select on channel 2
    setData(8'hA0);
    applyStimulus(1'b0, 2'd2, 4'b1111, 1'b1);
    repeat (5) runCycle();

    // Asynchronous reset while a word is held
    #2;
    rst = 1'b1;
    #1;
    checkResetState();
    @(posedge clk);
    #1;
    rst = 1'b0;
    resetModels();

    // Round-robin fairness, all channels valid
    for (int i = 0; i < 4; i++) chanCount[i] = 0;
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
    repeat (9) runCycle();
    for (int i = 0; i < 4; i++) checkOutput($sformatf("rr_count%0d", i), 32'(chanCount[i]), 2);
    applyStimulus(1'b1, 2'd0, 4'b1010, 1'b1);
    repeat (5) runCycle();

    // Backpressure holding the first word
    setData(8'h11);
    applyStimulus(1'b0, 2'd0, 4'b0001, 1'b1);
    runCycle();
    setData(8'h22);
    applyStimulus(1'b0, 2'd0, 4'b0001, 1'b0);
    repeat (3) runCycle();
    applyStimulus(1'b0, 2'd0, 4'b0001, 1'b1);
    repeat (2) runCycle();
    applyStimulus(1'b0, 2'd0, 4'b0000, 1'b1);
    repeat (2) runCycle();
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
    repeat (2) runCycle();

    // Out-of-range select for N=3, then mode switch after a channel-1 transfer
    setData(8'h50);
    applyStimulus(1'b0, 2'd3, 4'b1111, 1'b1);
    repeat (3) runCycle();
    applyStimulus(1'b0, 2'd1, 4'b1111, 1'b1);
    runCycle();
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
    repeat (3) runCycle();

    // Random traffic
    repeat (80) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
      inData = $urandom;
      runCycle();
    end
    applyStimulus(1'b0, 2'd0, 4'b0000, 1'b1);
    repeat (2) runCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
